// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between decode and a single-outstanding memory bus.
// Issues one bus request, waits for ack or timeout, and writes load data back.
module mem_access_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned TMO    = 15
) (
  input  logic              system1000,
  input  logic              system1000_rstn,
  input  logic [1:0]        ld_code_i,
  input  logic [4:0]        dst_reg_i,
  input  logic [4:0]        src_a_i,
  input  logic [4:0]        src_b_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic              mem_io_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o,
  output logic              wb_en_o,
  output logic [4:0]        wb_reg_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic              err_o
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned REG_W = 5;

  localparam logic [1:0] LD_NONE  = 2'b00;
  localparam logic [1:0] LD_STORE = 2'b10;
  localparam logic [1:0] LD_IO    = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REG_W-1:0]   dst_q, dst_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic               mem_io_q, mem_io_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic               wb_en_q, wb_en_d;
  logic [REG_W-1:0]   wb_reg_q, wb_reg_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               err_q, err_d;
  logic               drop_bus;
  logic               hazard;

  // The bus output registers double as the latched operation while in REQ.
  always_ff @(posedge system1000 or negedge system1000_rstn) begin
    if (!system1000_rstn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dst_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_io_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      wb_en_q     <= 1'b0;
      wb_reg_q    <= '0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dst_q       <= dst_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_io_q    <= mem_io_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_en_q     <= wb_en_d;
      wb_reg_q    <= wb_reg_d;
      wb_data_q   <= wb_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dst_d       = dst_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_io_d    = mem_io_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_en_d     = 1'b0;
    wb_reg_d    = '0;
    wb_data_d   = '0;
    err_d       = 1'b0;
    drop_bus    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ld_code_i != LD_NONE) begin
          state_d     = REQ;
          cnt_d       = '0;
          dst_d       = dst_reg_i;
          mem_req_d   = 1'b1;
          mem_we_d    = (ld_code_i == LD_STORE);
          mem_io_d    = (ld_code_i == LD_IO);
          mem_addr_d  = addr_i;
          mem_wdata_d = (ld_code_i == LD_STORE) ? wdata_i : '0;
        end
      end
      REQ: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem_ack_i) begin
          drop_bus = 1'b1;
          if (mem_we_q) begin
            state_d = IDLE;
          end else begin
            state_d   = WB;
            wb_en_d   = (dst_q != '0);
            wb_reg_d  = dst_q;
            wb_data_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            drop_bus = 1'b1;
            err_d    = 1'b1;
            state_d  = IDLE;
          end
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        drop_bus = 1'b1;
      end
    endcase

    if (drop_bus) begin
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_io_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end
  end

  // Decode must see the load result before using it; only r1..r31 can conflict.
  assign hazard = (dst_q != '0) && ((dst_q == src_a_i) || (dst_q == src_b_i));

  // Stall in WB follows the instruction currently in decode, so it is not registered.
  assign stall_o = (state_q == REQ) || ((state_q == WB) && hazard);

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_io_o    = mem_io_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign wb_en_o     = wb_en_q;
  assign wb_reg_o    = wb_reg_q;
  assign wb_data_o   = wb_data_q;
  assign err_o       = err_q;

endmodule
